decode: RTL and testbench

Decode/operand-fetch stage of the JARVIS core, directly upstream of `exec`. It accepts one 32-bit instruction per cycle from fetch and splits it into `op`, `in1` and `in2` for the execute stage. It holds the 32-entry register file with a writeback port and a pending-write scoreboard that stalls on read-after-write hazards. The result sits in an output register with a valid/ready handshake.

---
 rtl/decode_if.sv | 28 ++
 rtl/decode.sv | 99 +++++++++
 tb/tb_decode.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Fetch-to-decode, decode-to-exec and writeback signals of the JARVIS decode stage.
// The master side drives instructions, exec back-pressure and writeback; decode is the slave.
interface decode_if #(
  parameter int WIDTH = 32
);
  logic             if_valid;
  logic [31:0]      if_instr;
  logic             if_ready;
  logic             ex_valid;
  logic             ex_ready;
  logic [5:0]       ex_op;
  logic [WIDTH-1:0] ex_in1;
  logic [WIDTH-1:0] ex_in2;
  logic [4:0]       ex_rd;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output if_valid, if_instr, ex_ready, wb_en, wb_rd, wb_data,
    input  if_ready, ex_valid, ex_op, ex_in1, ex_in2, ex_rd
  );

  modport slave (
    input  if_valid, if_instr, ex_ready, wb_en, wb_rd, wb_data,
    output if_ready, ex_valid, ex_op, ex_in1, ex_in2, ex_rd
  );
endinterface

// File: rtl/decode.sv
// JARVIS decode/operand-fetch: register file with write-through bypass, pending-write
// scoreboard for RAW stalls, and a single valid/ready output register toward exec.
module decode #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);

  function automatic logic [WIDTH-1:0] sext16(input logic [15:0] v);
    return {{(WIDTH-16){v[15]}}, v};
  endfunction

  logic [WIDTH-1:0] regs [32];
  logic [31:0]      pending;

  logic             vld_p0;
  logic [5:0]       op_p0;
  logic [WIDTH-1:0] in1_p0;
  logic [WIDTH-1:0] in2_p0;
  logic [4:0]       rd_p0;

  logic [5:0]       op;
  logic [4:0]       rd, rs1, rs2;
  logic [15:0]      imm;
  logic             imm_form;
  logic             byp1, byp2, use1, use2, hazard, accept;
  logic [WIDTH-1:0] rdat1, rdat2, in2;
  logic [31:0]      pending_nxt;

  assign op       = bus.if_instr[31:26];
  assign rd       = bus.if_instr[25:21];
  assign rs1      = bus.if_instr[20:16];
  assign rs2      = bus.if_instr[15:11];
  assign imm      = bus.if_instr[15:0];
  assign imm_form = op[5];

  assign use1 = (rs1 != 5'd0);
  assign use2 = !imm_form && (rs2 != 5'd0);
  assign byp1 = bus.wb_en && (bus.wb_rd == rs1) && use1;
  assign byp2 = bus.wb_en && (bus.wb_rd == rs2) && (rs2 != 5'd0);

  // A writeback landing this cycle resolves the hazard through the bypass.
  assign hazard = (use1 && pending[rs1] && !byp1) || (use2 && pending[rs2] && !byp2);

  assign bus.if_ready = (!vld_p0 || bus.ex_ready) && !hazard;
  assign accept       = bus.if_valid && bus.if_ready;

  always_comb begin
    rdat1 = '0;
    rdat2 = '0;
    if (byp1)      rdat1 = bus.wb_data;
    else if (use1) rdat1 = regs[rs1];
    if (byp2)                rdat2 = bus.wb_data;
    else if (rs2 != 5'd0)    rdat2 = regs[rs2];
  end

  assign in2 = imm_form ? sext16(imm) : rdat2;

  // Set after clear: a newly accepted writer owns the register even if an older write lands now.
  always_comb begin
    pending_nxt = pending;
    if (bus.wb_en && (bus.wb_rd != 5'd0)) pending_nxt[bus.wb_rd] = 1'b0;
    if (accept && (rd != 5'd0))           pending_nxt[rd] = 1'b1;
  end

  // Stage p0: register file, scoreboard and exec output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pending <= '0;
      vld_p0  <= 1'b0;
      op_p0   <= '0;
      in1_p0  <= '0;
      in2_p0  <= '0;
      rd_p0   <= '0;
    end else begin
      if (bus.wb_en && (bus.wb_rd != 5'd0)) regs[bus.wb_rd] <= bus.wb_data;
      pending <= pending_nxt;
      if (accept) begin
        vld_p0 <= 1'b1;
        op_p0  <= op;
        in1_p0 <= rdat1;
        in2_p0 <= in2;
        rd_p0  <= rd;
      end else if (bus.ex_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.ex_valid = vld_p0;
  assign bus.ex_op    = op_p0;
  assign bus.ex_in1   = in1_p0;
  assign bus.ex_in2   = in2_p0;
  assign bus.ex_rd    = rd_p0;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: reset, operand fetch, immediate form, RAW stall/bypass,
// back-pressure, r0 rules and reset during a downstream stall.
module tb_decode;
  localparam int WIDTH = 32;
  localparam logic [5:0] ADD  = 6'h01;
  localparam logic [5:0] ADDI = 6'h21;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  decode_if #(.WIDTH(WIDTH)) bus ();
  decode #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_rd   = rd;
    bus.wb_data = d;
  endtask

  task automatic issue(input logic v, input logic [31:0] instr);
    bus.if_valid = v;
    bus.if_instr = instr;
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.ex_ready = 1'b1;
    wb(1'b1, 5'd1, 32'hFFFF_FFFF);
    issue(1'b1, mk(ADD, 5'd3, 5'd1, 5'd2));
    step();
    step();
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_op",    {26'd0, bus.ex_op}, 32'd0);
    chk("rst_in1",   bus.ex_in1, 32'd0);
    chk("rst_in2",   bus.ex_in2, 32'd0);
    chk("rst_rd",    {27'd0, bus.ex_rd}, 32'd0);
    chk("rst_ready", {31'd0, bus.if_ready}, 32'd1);
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'd0);

    // every register reads zero after reset (rd=0 so nothing becomes pending)
    for (int i = 1; i < 32; i++) begin
      issue(1'b1, mk(ADD, 5'd0, 5'(i), 5'(i)));
      step();
      chk("rf_zero", bus.ex_in1 | bus.ex_in2, 32'd0);
    end

    issue(1'b0, 32'd0);
    wb(1'b1, 5'd1, 32'd1);
    step();
    wb(1'b1, 5'd2, 32'd2);
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b1, mk(ADD, 5'd3, 5'd1, 5'd2));
    chk("add_ready", {31'd0, bus.if_ready}, 32'd1);
    step();
    issue(1'b0, 32'd0);
    chk("add_op",    {26'd0, bus.ex_op}, {26'd0, ADD});
    chk("add_in1",   bus.ex_in1, 32'd1);
    chk("add_in2",   bus.ex_in2, 32'd2);
    chk("add_rd",    {27'd0, bus.ex_rd}, 32'd3);
    chk("add_valid", {31'd0, bus.ex_valid}, 32'd1);

    // immediate form; r31 pending must not matter because rs2 field is imm bits
    wb(1'b1, 5'd1, 32'd5);
    step();
    wb(1'b0, 5'd0, 32'd0);
    chk("drain_valid", {31'd0, bus.ex_valid}, 32'd0);
    issue(1'b1, mk(ADD, 5'd31, 5'd0, 5'd0));
    step();
    issue(1'b1, mki(ADDI, 5'd6, 5'd1, 16'hFFFE));
    chk("imm_ready", {31'd0, bus.if_ready}, 32'd1);
    step();
    issue(1'b0, 32'd0);
    chk("imm_op",  {26'd0, bus.ex_op}, {26'd0, ADDI});
    chk("imm_in1", bus.ex_in1, 32'd5);
    chk("imm_in2", bus.ex_in2, 32'hFFFF_FFFE);
    chk("imm_rd",  {27'd0, bus.ex_rd}, 32'd6);

    // RAW stall on r4, resolved by same-cycle writeback bypass
    issue(1'b1, mk(ADD, 5'd4, 5'd0, 5'd0));
    step();
    issue(1'b1, mk(ADD, 5'd7, 5'd4, 5'd0));
    chk("raw_stall0", {31'd0, bus.if_ready}, 32'd0);
    step();
    chk("raw_stall1", {31'd0, bus.if_ready}, 32'd0);
    chk("raw_nodup",  {31'd0, bus.ex_valid}, 32'd0);
    wb(1'b1, 5'd4, 32'h0000_DEAD);
    #1;
    chk("raw_bypass_ready", {31'd0, bus.if_ready}, 32'd1);
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b0, 32'd0);
    chk("raw_in1", bus.ex_in1, 32'h0000_DEAD);
    chk("raw_rd",  {27'd0, bus.ex_rd}, 32'd7);
    issue(1'b1, mk(ADD, 5'd12, 5'd4, 5'd4));
    step();
    issue(1'b0, 32'd0);
    chk("rf_in1", bus.ex_in1, 32'h0000_DEAD);
    chk("rf_in2", bus.ex_in2, 32'h0000_DEAD);
    step();

    // back-pressure: A loads, B waits 3 cycles, then loads exactly once
    bus.ex_ready = 1'b0;
    issue(1'b1, mk(ADD, 5'd8, 5'd1, 5'd2));
    step();
    issue(1'b1, mk(ADD, 5'd9, 5'd2, 5'd1));
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", {31'd0, bus.if_ready}, 32'd0);
      step();
      chk("bp_hold", {bus.ex_in1[15:0], bus.ex_in2[7:0], 3'd0, bus.ex_rd}, {16'd5, 8'd2, 3'd0, 5'd8});
      chk("bp_valid", {31'd0, bus.ex_valid}, 32'd1);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, bus.if_ready}, 32'd1);
    step();
    issue(1'b0, 32'd0);
    chk("bp_b_rd",  {27'd0, bus.ex_rd}, 32'd9);
    chk("bp_b_in1", bus.ex_in1, 32'd2);
    chk("bp_b_in2", bus.ex_in2, 32'd5);
    step();
    chk("bp_empty", {31'd0, bus.ex_valid}, 32'd0);

    // r0 rules
    wb(1'b1, 5'd0, 32'h1234);
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b1, mk(ADD, 5'd0, 5'd0, 5'd0));
    step();
    issue(1'b1, mk(ADD, 5'd10, 5'd0, 5'd0));
    chk("r0_nostall", {31'd0, bus.if_ready}, 32'd1);
    step();
    chk("r0_in1", bus.ex_in1, 32'd0);

    // same-cycle set and clear of r5: set wins
    wb(1'b1, 5'd5, 32'h55);
    issue(1'b1, mk(ADD, 5'd5, 5'd0, 5'd0));
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b1, mk(ADD, 5'd11, 5'd5, 5'd0));
    chk("r5_pending", {31'd0, bus.if_ready}, 32'd0);
    wb(1'b1, 5'd5, 32'h77);
    #1;
    chk("r5_bypass_ready", {31'd0, bus.if_ready}, 32'd1);
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b0, 32'd0);
    chk("r5_in1", bus.ex_in1, 32'h77);
    step();

    // reset during a downstream stall clears output, registers and scoreboard
    bus.ex_ready = 1'b0;
    issue(1'b1, mk(ADD, 5'd13, 5'd0, 5'd0));
    step();
    issue(1'b0, 32'd0);
    step();
    chk("ms_held", {27'd0, bus.ex_rd}, 32'd13);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ms_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("ms_rd",    {27'd0, bus.ex_rd}, 32'd0);
    bus.ex_ready = 1'b1;
    issue(1'b1, mk(ADD, 5'd14, 5'd4, 5'd13));
    chk("ms_nopend", {31'd0, bus.if_ready}, 32'd1);
    step();
    issue(1'b0, 32'd0);
    chk("ms_rf_clr", bus.ex_in1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
